aes_ctr_sequencer: RTL and testbench

//  Sequences the AES-256-CTR core. Loads an IV, then issues NUM_BLOCKS counter blocks to the core's
//  AXI-Stream input. Outstanding blocks are limited by credits, so the keystream return FIFO cannot

---
 rtl/aes_ctr_pkg.sv | 29 ++
 rtl/credit_counter.sv | 38 +++
 rtl/aes_ctr_sequencer.sv | 131 +++++++++++++
 tb/tb_aes_ctr_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctr_pkg.sv
// rtl/aes_ctr_pkg.sv - shared types and the counter-increment helper for the AES-CTR sequencer
package aes_ctr_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_t;

    typedef struct packed {
        logic [AES_BLOCK_W-1:0] block;
        logic                   wrap;
    } ctr_inc_t;

    // Only the low ctr_w bits take part in the increment; wrap is the carry out of that field.
    function automatic ctr_inc_t ctr_inc(input logic [AES_BLOCK_W-1:0] block, input int ctr_w);
        ctr_inc_t res;
        logic     carry;
        carry     = 1'b1;
        res.block = block;
        for (int i = 0; i < AES_BLOCK_W; i++) begin
            if (i < ctr_w) begin
                res.block[i] = block[i] ^ carry;
                carry        = carry & block[i];
            end
        end
        res.wrap = carry;
        return res;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - counts counter blocks in flight between issue and keystream return
module credit_counter #(
    parameter int MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         take,
    input  logic                         give,
    output logic                         avail,
    output logic                         empty,
    output logic                         underflow,
    output logic [$clog2(MAX+1)-1:0]     count
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] count_q;
    logic          give_ok;

    assign empty     = (count_q == '0);
    assign avail     = (count_q < CW'(MAX));
    assign underflow = give && empty;
    assign count     = count_q;

    // A return with nothing outstanding is dropped, so a simultaneous take still counts.
    assign give_ok   = give && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (take && !give_ok) begin
            count_q <= count_q + CW'(1);
        end else if (!take && give_ok) begin
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/aes_ctr_sequencer.sv
// rtl/aes_ctr_sequencer.sv - issues credit-limited AES-CTR counter blocks to the AES core input stream
module aes_ctr_sequencer
    import aes_ctr_pkg::*;
#(
    parameter int DATA_WIDTH   = AES_BLOCK_W,
    parameter int CTR_WIDTH    = 32,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] cfg_iv,
    input  logic [31:0]           cfg_num_blocks,
    input  logic                  cfg_start,
    output logic                  busy,
    output logic                  done,
    output logic                  ctr_wrap,
    output logic                  credit_err,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic                  ks_return
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    seq_state_t            state_q;
    logic [DATA_WIDTH-1:0] block_q;
    logic [31:0]           num_q;
    logic [31:0]           issued_q;
    logic                  tlast_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  wrap_q;
    logic                  cerr_q;

    logic                  accept;
    logic                  credit_avail;
    logic                  credit_empty;
    logic                  credit_underflow;
    logic [CNT_W-1:0]      credit_count;
    logic                  drain_done;
    ctr_inc_t              nxt;

    assign m_axis_tvalid = (state_q == ISSUE) && credit_avail;
    assign accept        = m_axis_tvalid && m_axis_tready;
    assign nxt           = ctr_inc(block_q, CTR_WIDTH);
    assign drain_done    = credit_empty || ((credit_count == CNT_W'(1)) && ks_return);

    credit_counter #(
        .MAX (MAX_INFLIGHT)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .take      (accept),
        .give      (ks_return),
        .avail     (credit_avail),
        .empty     (credit_empty),
        .underflow (credit_underflow),
        .count     (credit_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            block_q  <= '0;
            num_q    <= '0;
            issued_q <= '0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
            cerr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (credit_underflow) begin
                cerr_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        block_q  <= cfg_iv;
                        num_q    <= cfg_num_blocks;
                        issued_q <= '0;
                        tlast_q  <= (cfg_num_blocks == 32'd1);
                        busy_q   <= 1'b1;
                        wrap_q   <= 1'b0;
                        cerr_q   <= 1'b0;
                        // An empty job still spends one busy cycle in DRAIN, so done lands two cycles after start.
                        state_q  <= (cfg_num_blocks == 32'd0) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (tlast_q) begin
                            state_q <= DRAIN;
                        end else begin
                            block_q  <= nxt.block;
                            issued_q <= issued_q + 32'd1;
                            tlast_q  <= (issued_q + 32'd2 == num_q);
                            if (nxt.wrap) begin
                                wrap_q <= 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign ctr_wrap     = wrap_q;
    assign credit_err   = cerr_q;
    assign m_axis_tdata = block_q;
    assign m_axis_tlast = tlast_q;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// tb/tb_aes_ctr_sequencer.sv - scoreboard bench for aes_ctr_sequencer with a queue-based reference model
module tb_aes_ctr_sequencer;

    localparam int MAXF = 8;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] cfg_iv = '0;
    logic [31:0]  cfg_num_blocks = '0;
    logic         cfg_start = 1'b0;
    logic         busy, done, ctr_wrap, credit_err;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid, m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic         ks_return = 1'b0;

    int errors = 0;
    int checks = 0;

    exp_t         sb[$];
    int           tb_inflight = 0;
    int           n_acc = 0;
    int           tr_mode = 0;
    int           ret_mode = 0;
    logic         ret_stray = 1'b0;
    logic         job_active = 1'b0;
    logic         done_due = 1'b0;
    logic         drain_pending = 1'b0;
    logic         zero_job = 1'b0;
    logic         exp_wrap = 1'b0;
    logic         exp_cerr = 1'b0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic         prev_last = 1'b0;

    aes_ctr_sequencer #(
        .DATA_WIDTH   (128),
        .CTR_WIDTH    (32),
        .MAX_INFLIGHT (MAXF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_iv         (cfg_iv),
        .cfg_num_blocks (cfg_num_blocks),
        .cfg_start      (cfg_start),
        .busy           (busy),
        .done           (done),
        .ctr_wrap       (ctr_wrap),
        .credit_err     (credit_err),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .ks_return      (ks_return)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Downstream stand-in: drives tready and keystream returns just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            2:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = ($urandom % 3) != 0;
        endcase
        ks_return = ret_stray ||
                    (tb_inflight > 0 && (ret_mode == 1 || (ret_mode == 2 && ($urandom % 2) == 1)));
    end

    // Monitor: compares the DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            logic acc;
            acc = m_axis_tvalid && m_axis_tready;
            check("tvalid", m_axis_tvalid, (sb.size() > 0) && (tb_inflight < MAXF));
            check("done", done, done_due);
            check("busy", busy, job_active && !done_due);
            check("ctr_wrap", ctr_wrap, exp_wrap);
            check("credit_err", credit_err, exp_cerr);
            if (prev_stall) begin
                check("hold_tvalid", m_axis_tvalid, 1'b1);
                check("hold_tdata", m_axis_tdata, prev_data);
                check("hold_tlast", m_axis_tlast, prev_last);
            end
            if (acc) begin
                n_acc++;
                if (sb.size() == 0) begin
                    check("unexpected_block", m_axis_tdata, '0);
                end else begin
                    e = sb.pop_front();
                    check("tdata", m_axis_tdata, e.data);
                    check("tlast", m_axis_tlast, e.last);
                    if (!e.last && e.data[31:0] == 32'hFFFF_FFFF) exp_wrap = 1'b1;
                    if (e.last) drain_pending = 1'b1;
                end
            end
            if (ks_return && tb_inflight == 0) exp_cerr = 1'b1;
            tb_inflight = tb_inflight + (acc ? 1 : 0) - ((ks_return && tb_inflight > 0) ? 1 : 0);
            if (done_due) job_active = 1'b0;
            done_due = 1'b0;
            if (drain_pending && tb_inflight == 0) begin
                done_due      = 1'b1;
                drain_pending = 1'b0;
            end
            if (zero_job) begin
                done_due = 1'b1;
                zero_job = 1'b0;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic start_job(input logic [127:0] iv, input logic [31:0] num);
        @(negedge clk);
        #1;
        cfg_iv         = iv;
        cfg_num_blocks = num;
        cfg_start      = 1'b1;
        @(posedge clk);
        #1;
        cfg_start  = 1'b0;
        exp_wrap   = 1'b0;
        exp_cerr   = 1'b0;
        job_active = 1'b1;
        for (int i = 0; i < int'(num); i++) begin
            exp_t e;
            e.data = {iv[127:32], iv[31:0] + 32'(i)};
            e.last = (i == int'(num) - 1);
            sb.push_back(e);
        end
        if (num == 0) zero_job = 1'b1;
    endtask

    task automatic poke_start();
        @(negedge clk);
        #1;
        cfg_iv         = {$urandom, $urandom, $urandom, $urandom};
        cfg_num_blocks = $urandom_range(1, 50);
        cfg_start      = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_job();
        int n;
        n = 0;
        while (job_active && n < 2000) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("job_complete", job_active, 1'b0);
        @(negedge clk);
    endtask

    function automatic logic [127:0] rand_iv(input logic near_wrap);
        logic [127:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        if (near_wrap) v[31:0] = 32'hFFFF_FFFF - $urandom_range(0, 6);
        return v;
    endfunction

    initial begin
        int base;
        int n;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tdata", m_axis_tdata, '0);
        check("rst_tlast", m_axis_tlast, 1'b0);

        // Wrap across the low field, every block returned immediately.
        tr_mode  = 1;
        ret_mode = 1;
        start_job({96'h0123_4567_89AB_CDEF_0F1E_2D3C, 32'hFFFF_FFFE}, 32'd4);
        wait_job();
        check("t1_wrap_sticky", ctr_wrap, 1'b1);

        // Credit exhaustion then one return per cycle.
        tr_mode  = 1;
        ret_mode = 0;
        base     = n_acc;
        start_job(rand_iv(1'b0), 32'd20);
        repeat (15) @(negedge clk);
        #1;
        check("t2_accepts_at_limit", 32'(n_acc - base), 32'd8);
        ret_mode = 1;
        wait_job();
        check("t2_total_accepts", 32'(n_acc - base), 32'd20);

        // Alternating and random backpressure.
        tr_mode  = 2;
        ret_mode = 2;
        start_job(rand_iv(1'b1), 32'd17);
        wait_job();
        tr_mode = 3;
        for (int j = 0; j < 6; j++) begin
            start_job(rand_iv(j[0]), 32'($urandom_range(1, 30)));
            wait_job();
        end

        // Empty job, single block, and a start while busy.
        start_job(rand_iv(1'b0), 32'd0);
        wait_job();
        start_job(rand_iv(1'b0), 32'd1);
        wait_job();
        start_job(rand_iv(1'b1), 32'd12);
        repeat (3) @(negedge clk);
        poke_start();
        wait_job();

        // Reset mid-issue with five blocks in flight.
        tr_mode  = 1;
        ret_mode = 0;
        start_job({96'hA5A5_5A5A_1234_5678_DEAD_BEEF, 32'hFFFF_FFFD}, 32'd20);
        n = 0;
        while (tb_inflight != 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_reached_inflight5", 32'(tb_inflight), 32'd5);
        tr_mode = 0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        sb.delete();
        tb_inflight   = 0;
        job_active    = 1'b0;
        done_due      = 1'b0;
        drain_pending = 1'b0;
        exp_wrap      = 1'b0;
        exp_cerr      = 1'b0;
        prev_stall    = 1'b0;
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        check("t5_tvalid", m_axis_tvalid, 1'b0);
        check("t5_tdata", m_axis_tdata, '0);
        check("t5_tlast", m_axis_tlast, 1'b0);
        check("t5_wrap", ctr_wrap, 1'b0);
        tr_mode  = 3;
        ret_mode = 2;
        start_job(rand_iv(1'b0), 32'd9);
        wait_job();

        // Stray keystream return while idle.
        @(negedge clk);
        #1;
        ret_stray = 1'b1;
        @(posedge clk);
        #2;
        ret_stray = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_credit_err", credit_err, 1'b1);
        check("t6_inflight_zero", 32'(tb_inflight), 32'd0);
        start_job(rand_iv(1'b0), 32'd3);
        wait_job();
        check("t6_err_cleared", credit_err, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
